// File: rtl/leve_axir_arb.sv
// Two-to-one AXI read-channel arbiter: ports I and D share one read initiator.
// One burst in flight at a time; the grant is held from address issue to the RLAST beat.
module leve_axir_arb #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64,
  parameter int unsigned RR = 1
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          I_ARVALID,
  output logic          I_ARREADY,
  input  logic [AW-1:0] I_ARADDR,
  input  logic [1:0]    I_ARBURST,
  input  logic [7:0]    I_ARLEN,
  output logic          I_RVALID,
  input  logic          I_RREADY,
  output logic [DW-1:0] I_RDATA,
  output logic          I_RLAST,
  input  logic          D_ARVALID,
  output logic          D_ARREADY,
  input  logic [AW-1:0] D_ARADDR,
  input  logic [1:0]    D_ARBURST,
  input  logic [7:0]    D_ARLEN,
  output logic          D_RVALID,
  input  logic          D_RREADY,
  output logic [DW-1:0] D_RDATA,
  output logic          D_RLAST,
  output logic          M_ARVALID,
  input  logic          M_ARREADY,
  output logic [AW-1:0] M_ARADDR,
  output logic [1:0]    M_ARBURST,
  output logic [7:0]    M_ARLEN,
  input  logic          M_RVALID,
  output logic          M_RREADY,
  input  logic [DW-1:0] M_RDATA,
  input  logic          M_RLAST,
  output logic          GNT_I,
  output logic          GNT_D,
  output logic          ERR
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e     r_state;
  logic       r_gnt_i;
  logic       r_gnt_d;
  logic       r_err;
  logic       r_last_d;
  logic [7:0] r_cnt;

  logic w_in_addr;
  logic w_in_data;
  logic w_tie_d;
  logic w_pick_d;

  assign w_in_addr = (r_state == StAddr);
  assign w_in_data = (r_state == StData);

  // On a tie, round-robin grants the port that was not served last.
  assign w_tie_d  = (RR != 0) ? !r_last_d : 1'b1;
  assign w_pick_d = D_ARVALID & (!I_ARVALID | w_tie_d);

  assign M_ARVALID = w_in_addr & (r_gnt_d ? D_ARVALID : I_ARVALID);
  assign M_ARADDR  = r_gnt_d ? D_ARADDR  : I_ARADDR;
  assign M_ARBURST = r_gnt_d ? D_ARBURST : I_ARBURST;
  assign M_ARLEN   = r_gnt_d ? D_ARLEN   : I_ARLEN;
  assign I_ARREADY = w_in_addr & r_gnt_i & M_ARREADY;
  assign D_ARREADY = w_in_addr & r_gnt_d & M_ARREADY;

  assign M_RREADY = w_in_data & (r_gnt_d ? D_RREADY : I_RREADY);
  assign I_RVALID = w_in_data & r_gnt_i & M_RVALID;
  assign D_RVALID = w_in_data & r_gnt_d & M_RVALID;
  assign I_RDATA  = M_RDATA;
  assign D_RDATA  = M_RDATA;
  assign I_RLAST  = M_RLAST;
  assign D_RLAST  = M_RLAST;

  assign GNT_I = r_gnt_i;
  assign GNT_D = r_gnt_d;
  assign ERR   = r_err;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= StIdle;
      r_gnt_i  <= 1'b0;
      r_gnt_d  <= 1'b0;
      r_err    <= 1'b0;
      r_last_d <= 1'b1;
      r_cnt    <= 8'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (I_ARVALID | D_ARVALID) begin
            r_gnt_d <= w_pick_d;
            r_gnt_i <= !w_pick_d;
            r_state <= StAddr;
          end
        end
        StAddr: begin
          if (M_ARVALID & M_ARREADY) begin
            r_cnt   <= M_ARLEN;
            r_state <= StData;
          end
        end
        StData: begin
          if (M_RVALID & M_RREADY) begin
            if (M_RLAST) begin
              if (r_cnt != 8'd0) r_err <= 1'b1;
              r_last_d <= r_gnt_d;
              r_gnt_i  <= 1'b0;
              r_gnt_d  <= 1'b0;
              r_state  <= StIdle;
            end else if (r_cnt == 8'd0) begin
              r_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_leve_axir_arb.sv
// Directed bench: instance 0 uses round-robin ties, instance 1 uses fixed D priority.
module tb_leve_axir_arb;

  logic clk;
  logic rst_n;

  logic [1:0]  i_arvalid, i_arready, i_rvalid, i_rready, i_rlast;
  logic [1:0]  d_arvalid, d_arready, d_rvalid, d_rready, d_rlast;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [1:0]  gnt_i, gnt_d, err;
  logic [63:0] i_araddr [2];
  logic [63:0] d_araddr [2];
  logic [63:0] m_araddr [2];
  logic [63:0] i_rdata  [2];
  logic [63:0] d_rdata  [2];
  logic [63:0] m_rdata  [2];
  logic [1:0]  i_arburst [2];
  logic [1:0]  d_arburst [2];
  logic [1:0]  m_arburst [2];
  logic [7:0]  i_arlen  [2];
  logic [7:0]  d_arlen  [2];
  logic [7:0]  m_arlen  [2];

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    leve_axir_arb #(
      .AW(64),
      .DW(64),
      .RR((g == 0) ? 1 : 0)
    ) u_dut (
      .CLK      (clk),
      .RSTn     (rst_n),
      .I_ARVALID(i_arvalid[g]),
      .I_ARREADY(i_arready[g]),
      .I_ARADDR (i_araddr[g]),
      .I_ARBURST(i_arburst[g]),
      .I_ARLEN  (i_arlen[g]),
      .I_RVALID (i_rvalid[g]),
      .I_RREADY (i_rready[g]),
      .I_RDATA  (i_rdata[g]),
      .I_RLAST  (i_rlast[g]),
      .D_ARVALID(d_arvalid[g]),
      .D_ARREADY(d_arready[g]),
      .D_ARADDR (d_araddr[g]),
      .D_ARBURST(d_arburst[g]),
      .D_ARLEN  (d_arlen[g]),
      .D_RVALID (d_rvalid[g]),
      .D_RREADY (d_rready[g]),
      .D_RDATA  (d_rdata[g]),
      .D_RLAST  (d_rlast[g]),
      .M_ARVALID(m_arvalid[g]),
      .M_ARREADY(m_arready[g]),
      .M_ARADDR (m_araddr[g]),
      .M_ARBURST(m_arburst[g]),
      .M_ARLEN  (m_arlen[g]),
      .M_RVALID (m_rvalid[g]),
      .M_RREADY (m_rready[g]),
      .M_RDATA  (m_rdata[g]),
      .M_RLAST  (m_rlast[g]),
      .GNT_I    (gnt_i[g]),
      .GNT_D    (gnt_d[g]),
      .ERR      (err[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Entered in IDLE, just after an edge, with the requests already driven.
  task automatic run_burst(input int p, input bit exp_d, input int nbeats, input int last_at,
                           input int stall, input int err_beat);
    logic [63:0] exp_addr;
    logic [7:0]  exp_len;
    #1;
    check("idle_no_arvalid", m_arvalid[p], 1'b0);
    tick();
    exp_addr = exp_d ? d_araddr[p] : i_araddr[p];
    exp_len  = exp_d ? d_arlen[p]  : i_arlen[p];
    check("gnt_d", gnt_d[p], exp_d);
    check("gnt_i", gnt_i[p], !exp_d);
    check("m_arvalid", m_arvalid[p], 1'b1);
    check("m_araddr", m_araddr[p], exp_addr);
    check("m_arlen", {56'd0, m_arlen[p]}, {56'd0, exp_len});
    for (int s = 0; s < stall; s++) begin
      if (s == 1) begin
        if (exp_d) i_arvalid[p] = 1'b1;
        else d_arvalid[p] = 1'b1;
      end
      tick();
      check("stall_arvalid", m_arvalid[p], 1'b1);
      check("stall_addr", m_araddr[p], exp_addr);
      check("stall_gnt_d", gnt_d[p], exp_d);
    end
    m_arready[p] = 1'b1;
    #1;
    check("win_arready", exp_d ? d_arready[p] : i_arready[p], 1'b1);
    check("lose_arready", exp_d ? i_arready[p] : d_arready[p], 1'b0);
    tick();
    m_arready[p] = 1'b0;
    if (exp_d) begin
      d_arvalid[p] = 1'b0;
      d_rready[p]  = 1'b1;
    end else begin
      i_arvalid[p] = 1'b0;
      i_rready[p]  = 1'b1;
    end
    for (int b = 1; b <= nbeats; b++) begin
      m_rvalid[p] = 1'b1;
      m_rlast[p]  = (b == last_at);
      m_rdata[p]  = {32'(p), 32'(b)} ^ 64'hA5A5_0000_0000_5A5A;
      #1;
      check("win_rvalid", exp_d ? d_rvalid[p] : i_rvalid[p], 1'b1);
      check("lose_rvalid", exp_d ? i_rvalid[p] : d_rvalid[p], 1'b0);
      check("m_rready", m_rready[p], 1'b1);
      check("win_rdata", exp_d ? d_rdata[p] : i_rdata[p], m_rdata[p]);
      tick();
      check("err", err[p], (err_beat != 0) && (b >= err_beat));
    end
    m_rvalid[p] = 1'b0;
    m_rlast[p]  = 1'b0;
    i_rready[p] = 1'b0;
    d_rready[p] = 1'b0;
    #1;
    check("end_gnt_i", gnt_i[p], 1'b0);
    check("end_gnt_d", gnt_d[p], 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    {i_arvalid, i_rready, d_arvalid, d_rready, m_arready, m_rvalid, m_rlast} = '0;
    for (int p = 0; p < 2; p++) begin
      i_araddr[p]  = 64'h1000;
      d_araddr[p]  = 64'h2000;
      i_arburst[p] = 2'b01;
      d_arburst[p] = 2'b01;
      i_arlen[p]   = 8'd3;
      d_arlen[p]   = 8'd1;
      m_rdata[p]   = '0;
    end
    do_reset();
    for (int p = 0; p < 2; p++) begin
      check("rst_gnt_i", gnt_i[p], 1'b0);
      check("rst_gnt_d", gnt_d[p], 1'b0);
      check("rst_err", err[p], 1'b0);
      check("rst_m_arvalid", m_arvalid[p], 1'b0);
      check("rst_m_rready", m_rready[p], 1'b0);
    end

    // Single I burst of four beats.
    i_arvalid[0] = 1'b1;
    run_burst(0, 1'b0, 4, 4, 0, 0);

    // Round-robin tie: I first after reset, then D, then the tie alternates back to I.
    do_reset();
    i_arvalid[0] = 1'b1;
    d_arvalid[0] = 1'b1;
    run_burst(0, 1'b0, 4, 4, 0, 0);
    run_burst(0, 1'b1, 2, 2, 0, 0);
    i_arvalid[0] = 1'b1;
    d_arvalid[0] = 1'b1;
    run_burst(0, 1'b0, 4, 4, 0, 0);
    run_burst(0, 1'b1, 2, 2, 0, 0);

    // Fixed priority: D wins every tie; I waits until D stops asking.
    i_arvalid[1] = 1'b1;
    d_arvalid[1] = 1'b1;
    run_burst(1, 1'b1, 2, 2, 0, 0);
    d_arvalid[1] = 1'b1;
    run_burst(1, 1'b1, 2, 2, 0, 0);
    run_burst(1, 1'b0, 4, 4, 0, 0);

    // Address stall of five cycles; D arrives mid-stall and is served afterwards.
    do_reset();
    i_arvalid[0] = 1'b1;
    run_burst(0, 1'b0, 4, 4, 5, 0);
    run_burst(0, 1'b1, 2, 2, 0, 0);

    // Asynchronous reset in the middle of a data burst.
    i_arvalid[0] = 1'b1;
    tick();
    m_arready[0] = 1'b1;
    tick();
    i_arvalid[0] = 1'b0;
    m_arready[0] = 1'b0;
    m_rvalid[0]  = 1'b1;
    i_rready[0]  = 1'b1;
    tick();
    check("pre_rst_m_rready", m_rready[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_gnt_i", gnt_i[0], 1'b0);
    check("arst_m_rready", m_rready[0], 1'b0);
    check("arst_i_rvalid", i_rvalid[0], 1'b0);
    m_rvalid[0] = 1'b0;
    i_rready[0] = 1'b0;
    rst_n = 1'b1;
    tick();
    i_arvalid[0] = 1'b1;
    run_burst(0, 1'b0, 4, 4, 0, 0);

    // ARLEN=3 but RLAST on beat 2: error on the early last beat.
    do_reset();
    i_arvalid[0] = 1'b1;
    run_burst(0, 1'b0, 2, 2, 0, 2);

    // ARLEN=0 with RLAST on beat 2: error already on the first beat.
    do_reset();
    i_arlen[0]   = 8'd0;
    i_arvalid[0] = 1'b1;
    run_burst(0, 1'b0, 2, 2, 0, 1);
    tick();
    check("err_sticky", err[0], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
